pipe_wb_regfile: RTL and testbench

- Write-back end of the MEM/WB pipeline interface. Consumes the WB-stage signals `wwreg`, `wm2reg`, `wmo`, `walu` and `wrn`.
- Selects the write-back data and commits it into a 32x32 general register file.
- Serves two combinational read ports to ID, with write-through bypass, and counts committed register writes for performance monitoring.

---
 rtl/pipe_wb_regfile_pkg.sv | 13 +
 rtl/pipe_wb_regfile_if.sv | 26 ++
 rtl/pipe_wb_regfile_regfile_2r1w.sv | 62 ++++++
 rtl/pipe_wb_regfile.sv | 63 ++++++
 tb/tb_pipe_wb_regfile.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_wb_regfile_pkg.sv
// Shared constants for the write-back register file slice: default widths
// and the hard-wired zero register number.
package pipe_wb_regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NREGS_DEF  = 32;
   localparam int CNT_W      = 32;

   // Register 0 always reads as zero and never accepts a write.
   localparam int REG_ZERO   = 0;

endpackage

// File: rtl/pipe_wb_regfile_if.sv
// MEM/WB write-back bundle: register-write enable, data select, the two
// candidate data words and the destination register number.
interface pipe_wb_regfile_if
   import pipe_wb_regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              wwreg;
   logic              wm2reg;
   logic [DATA_W-1:0] wmo;
   logic [DATA_W-1:0] walu;
   logic [ADDR_W-1:0] wrn;

   // The pipeline's MEM/WB register drives the bundle.
   modport master (
      output wwreg, wm2reg, wmo, walu, wrn
   );

   // The register file consumes it.
   modport slave (
      input wwreg, wm2reg, wmo, walu, wrn
   );

endinterface

// File: rtl/pipe_wb_regfile_regfile_2r1w.sv
// Two-read, one-write register array with asynchronous clear, a hard-wired
// zero register and write-through bypass on both read ports.
module regfile_2r1w
   import pipe_wb_regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NREGS  = NREGS_DEF
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] rna,
   input  logic [ADDR_W-1:0] rnb,
   output logic [DATA_W-1:0] qa,
   output logic [DATA_W-1:0] qb
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs [NREGS];

   // Storage update: reset wipes every entry at once; register 0 is never
   // written so it stays zero even if the caller forgets to filter it.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != ZERO_ADDR)) begin
         regs[waddr] <= wdata;
      end
   end

   // Read port A: zero register first, then the value being written this
   // cycle, otherwise the stored word, so ID never has to stall on WB.
   always_comb begin
      qa = '0;
      if (rna != ZERO_ADDR) begin
         if (we && (waddr == rna)) begin
            qa = wdata;
         end else begin
            qa = regs[rna];
         end
      end
   end

   // Read port B: identical priority to port A.
   always_comb begin
      qb = '0;
      if (rnb != ZERO_ADDR) begin
         if (we && (waddr == rnb)) begin
            qb = wdata;
         end else begin
            qb = regs[rnb];
         end
      end
   end

endmodule

// File: rtl/pipe_wb_regfile.sv
// Write-back end of the pipeline: picks memory or ALU data, decides whether
// the write really commits, stores it in the register file and counts
// committed writes for performance monitoring.
module pipe_wb_regfile
   import pipe_wb_regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NREGS  = NREGS_DEF
) (
   input  logic              clock,
   input  logic              resetn,
   pipe_wb_regfile_if.slave  wb,
   input  logic [ADDR_W-1:0] rna,
   input  logic [ADDR_W-1:0] rnb,
   input  logic              cnt_clr,
   output logic [DATA_W-1:0] qa,
   output logic [DATA_W-1:0] qb,
   output logic [DATA_W-1:0] wdi,
   output logic              wcommit,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic [CNT_W-1:0] cnt_q;

   // Write-back data select and commit decision; writes aimed at register 0
   // are dropped here so they are neither stored nor counted.
   always_comb begin
      wdi     = wb.wm2reg ? wb.wmo : wb.walu;
      wcommit = wb.wwreg && (wb.wrn != ADDR_W'(REG_ZERO));
   end

   regfile_2r1w #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
   ) u_regfile (
      .clock  (clock),
      .resetn (resetn),
      .we     (wcommit),
      .waddr  (wb.wrn),
      .wdata  (wdi),
      .rna    (rna),
      .rnb    (rnb),
      .qa     (qa),
      .qb     (qb)
   );

   // Retire counter: clear wins over a same-cycle commit, and the count
   // simply wraps at 2^32 with no overflow indication.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (wcommit) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Self-checking bench for pipe_wb_regfile: directed scenarios plus a random
// back-to-back run, with expected values queued when stimulus is applied
// and popped when the outputs are sampled.
module tb_pipe_wb_regfile;
   import pipe_wb_regfile_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   logic          clock = 1'b0;
   logic          resetn;
   logic [AW-1:0] rna;
   logic [AW-1:0] rnb;
   logic          cnt_clr;
   logic [DW-1:0] qa;
   logic [DW-1:0] qb;
   logic [DW-1:0] wdi;
   logic          wcommit;
   logic [31:0]   retire_cnt;

   exp_t        expQ[$];
   exp_t        e;
   int          checks = 0;
   int          passes = 0;
   logic [31:0] model[32];
   logic [31:0] modelCnt;

   pipe_wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) wb ();

   pipe_wb_regfile dut (
      .clock      (clock),
      .resetn     (resetn),
      .wb         (wb),
      .rna        (rna),
      .rnb        (rnb),
      .cnt_clr    (cnt_clr),
      .qa         (qa),
      .qb         (qb),
      .wdi        (wdi),
      .wcommit    (wcommit),
      .retire_cnt (retire_cnt)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive the write-back bundle and counter clear.
   task automatic applyStimulus(input logic we, input logic m2r,
                                input logic [31:0] mo, input logic [31:0] alu,
                                input logic [4:0] rn, input logic clr);
      wb.wwreg  = we;
      wb.wm2reg = m2r;
      wb.wmo    = mo;
      wb.walu   = alu;
      wb.wrn    = rn;
      cnt_clr   = clr;
   endtask

   // Expected read value from the reference model plus the bypass rule.
   function automatic logic [31:0] expRead(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (wb.wwreg && (wb.wrn == a)) return wb.wm2reg ? wb.wmo : wb.walu;
      return model[a];
   endfunction

   // Advance one rising edge and update the reference model from the
   // stimulus that was present at that edge.
   task automatic clockEdge();
      logic        commit;
      logic [31:0] data;
      @(posedge clock);
      commit = wb.wwreg && (wb.wrn != 5'd0);
      data   = wb.wm2reg ? wb.wmo : wb.walu;
      if (cnt_clr) modelCnt = 32'h0;
      else if (commit) modelCnt = modelCnt + 32'd1;
      if (commit) model[wb.wrn] = data;
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      rna = 5'd5;
      rnb = 5'd31;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      modelCnt = 32'h0;
      #3;
      expQ.push_back('{name: "reset_qa", exp: 32'h0});
      expQ.push_back('{name: "reset_qb", exp: 32'h0});
      expQ.push_back('{name: "reset_cnt", exp: 32'h0});
      e = expQ.pop_front(); checks++;
      if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qa, e.exp); else passes++;
      e = expQ.pop_front(); checks++;
      if (qb !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qb, e.exp); else passes++;
      e = expQ.pop_front(); checks++;
      if (retire_cnt !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, retire_cnt, e.exp); else passes++;
      @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_alu_mem_select();
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678, 5'd3, 1'b0);
      rna = 5'd3;
      #1;
      expQ.push_back('{name: "alu_wdi", exp: 32'h12345678});
      expQ.push_back('{name: "alu_wcommit", exp: 32'h1});
      e = expQ.pop_front(); checks++;
      if (wdi !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, wdi, e.exp); else passes++;
      e = expQ.pop_front(); checks++;
      if ({31'b0, wcommit} !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, wcommit, e.exp); else passes++;
      clockEdge();
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      #1;
      expQ.push_back('{name: "alu_reg3", exp: 32'h12345678});
      e = expQ.pop_front(); checks++;
      if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qa, e.exp); else passes++;
      @(negedge clock);
      applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'd4, 1'b0);
      #1;
      expQ.push_back('{name: "mem_wdi", exp: 32'hDEADBEEF});
      e = expQ.pop_front(); checks++;
      if (wdi !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, wdi, e.exp); else passes++;
      clockEdge();
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      rnb = 5'd4;
      #1;
      expQ.push_back('{name: "mem_reg4", exp: 32'hDEADBEEF});
      e = expQ.pop_front(); checks++;
      if (qb !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qb, e.exp); else passes++;
   endtask

   task automatic test_bypass();
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h11, 5'd7, 1'b0);
      clockEdge();
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h22, 5'd7, 1'b0);
      rna = 5'd7;
      rnb = 5'd7;
      #1;
      expQ.push_back('{name: "bypass_qa", exp: 32'h22});
      expQ.push_back('{name: "bypass_qb", exp: 32'h22});
      e = expQ.pop_front(); checks++;
      if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qa, e.exp); else passes++;
      e = expQ.pop_front(); checks++;
      if (qb !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qb, e.exp); else passes++;
      clockEdge();
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      #1;
      expQ.push_back('{name: "bypass_reg7", exp: 32'h22});
      e = expQ.pop_front(); checks++;
      if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qa, e.exp); else passes++;
   endtask

   task automatic test_reg_zero();
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 1'b0);
      rna = 5'd0;
      #1;
      expQ.push_back('{name: "zero_wcommit", exp: 32'h0});
      expQ.push_back('{name: "zero_qa_before", exp: 32'h0});
      e = expQ.pop_front(); checks++;
      if ({31'b0, wcommit} !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, wcommit, e.exp); else passes++;
      e = expQ.pop_front(); checks++;
      if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qa, e.exp); else passes++;
      clockEdge();
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      #1;
      expQ.push_back('{name: "zero_qa_after", exp: 32'h0});
      expQ.push_back('{name: "zero_cnt", exp: 32'd4});
      e = expQ.pop_front(); checks++;
      if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qa, e.exp); else passes++;
      e = expQ.pop_front(); checks++;
      if (retire_cnt !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, retire_cnt, e.exp); else passes++;
   endtask

   task automatic test_write_disabled();
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h99, 5'd9, 1'b0);
      clockEdge();
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'hAA, 5'd9, 1'b0);
      rna = 5'd9;
      #1;
      expQ.push_back('{name: "wdis_qa_before", exp: 32'h99});
      expQ.push_back('{name: "wdis_wcommit", exp: 32'h0});
      e = expQ.pop_front(); checks++;
      if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qa, e.exp); else passes++;
      e = expQ.pop_front(); checks++;
      if ({31'b0, wcommit} !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, wcommit, e.exp); else passes++;
      clockEdge();
      #1;
      expQ.push_back('{name: "wdis_qa_after", exp: 32'h99});
      e = expQ.pop_front(); checks++;
      if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qa, e.exp); else passes++;
   endtask

   task automatic test_counter();
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);
      clockEdge();
      expQ.push_back('{name: "cnt_clear", exp: 32'd0});
      e = expQ.pop_front(); checks++;
      if (retire_cnt !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, retire_cnt, e.exp); else passes++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         applyStimulus(1'b1, 1'b0, 32'h0, 32'h100 + 32'(i), 5'(10 + i), 1'b0);
         clockEdge();
      end
      expQ.push_back('{name: "cnt_three", exp: 32'd3});
      e = expQ.pop_front(); checks++;
      if (retire_cnt !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, retire_cnt, e.exp); else passes++;
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h55, 5'd13, 1'b1);
      clockEdge();
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      rna = 5'd13;
      rnb = 5'd11;
      #1;
      expQ.push_back('{name: "cnt_clr_priority", exp: 32'd0});
      expQ.push_back('{name: "clr_cycle_write", exp: 32'h55});
      expQ.push_back('{name: "cnt_reg11", exp: 32'h101});
      e = expQ.pop_front(); checks++;
      if (retire_cnt !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, retire_cnt, e.exp); else passes++;
      e = expQ.pop_front(); checks++;
      if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qa, e.exp); else passes++;
      e = expQ.pop_front(); checks++;
      if (qb !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, qb, e.exp); else passes++;
      force dut.cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.cnt_q;
      modelCnt = 32'hFFFFFFFF;
      #1;
      expQ.push_back('{name: "cnt_preload", exp: 32'hFFFFFFFF});
      e = expQ.pop_front(); checks++;
      if (retire_cnt !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, retire_cnt, e.exp); else passes++;
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h1, 5'd14, 1'b0);
      clockEdge();
      expQ.push_back('{name: "cnt_wrap", exp: 32'h0});
      e = expQ.pop_front(); checks++;
      if (retire_cnt !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, retire_cnt, e.exp); else passes++;
   endtask

   task automatic test_back_to_back();
      logic [4:0] rn;
      for (int n = 0; n < 60; n++) begin
         @(negedge clock);
         rn = 5'($urandom_range(0, 31));
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, rn, 1'($urandom_range(0, 15) == 0));
         rna = ($urandom_range(0, 2) == 0) ? rn : 5'($urandom_range(0, 31));
         rnb = ($urandom_range(0, 2) == 0) ? rn : 5'($urandom_range(0, 31));
         #1;
         expQ.push_back('{name: "b2b_qa", exp: expRead(rna)});
         expQ.push_back('{name: "b2b_qb", exp: expRead(rnb)});
         expQ.push_back('{name: "b2b_wdi", exp: wb.wm2reg ? wb.wmo : wb.walu});
         expQ.push_back('{name: "b2b_cnt", exp: modelCnt});
         e = expQ.pop_front(); checks++;
         if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", e.name, qa, e.exp, n); else passes++;
         e = expQ.pop_front(); checks++;
         if (qb !== e.exp) $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", e.name, qb, e.exp, n); else passes++;
         e = expQ.pop_front(); checks++;
         if (wdi !== e.exp) $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", e.name, wdi, e.exp, n); else passes++;
         e = expQ.pop_front(); checks++;
         if (retire_cnt !== e.exp) $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", e.name, retire_cnt, e.exp, n); else passes++;
         clockEdge();
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h77, 5'd20, 1'b0);
      #2;
      resetn = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      modelCnt = 32'h0;
      #1;
      expQ.push_back('{name: "midrst_cnt", exp: 32'h0});
      e = expQ.pop_front(); checks++;
      if (retire_cnt !== e.exp) $display("[TB] FAIL %s: got %h expected %h", e.name, retire_cnt, e.exp); else passes++;
      @(posedge clock);
      #1;
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      resetn = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rna = 5'(i);
         rnb = 5'(31 - i);
         #1;
         expQ.push_back('{name: "midrst_qa", exp: expRead(rna)});
         e = expQ.pop_front(); checks++;
         if (qa !== e.exp) $display("[TB] FAIL %s: got %h expected %h (reg %0d)", e.name, qa, e.exp, i); else passes++;
      end
   endtask

   // Scenario sequence and final summary.
   initial begin
      test_reset();
      test_alu_mem_select();
      test_bypass();
      test_reg_zero();
      test_write_disabled();
      test_counter();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
